multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Next-generation multicycle MIPS control unit with an explicit state register, main decode and ALU decode in one block.
- Adds addi, bne and j to the base lw/sw/R-type/beq set.
- Adds a memory ready handshake with wait states and a bounded timeout.
- Adds illegal-opcode trapping and a retired-instruction counter.
- Drives the datapath muxes and write enables of the multicycle core. Opcode and Funct come from the instruction register.

Parameters:
ALUCTRL_W, 3, ALUControl width; must be >=3; codes zero-extended.
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1.
TIMEOUT, 15, max wait cycles in a memory state before mem_err; must be >=1.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
Opcode  in  6  instruction[31:26]
Funct  in  6  instruction[5:0]
mem_ready  in  1  memory completes the current access this cycle
MemtoReg  out  1  register write data from MDR
RegDst  out  1  1 = rd, 0 = rt
IorD  out  1  memory address from ALUOut
PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
ALUSrcB  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
ALUSrcA  out  1  1 = register A, 0 = PC
IRWrite  out  1  load instruction register
MemWrite  out  1  memory write
PCWrite  out  1  unconditional PC load
Branch  out  1  PC load if zero
BranchNe  out  1  PC load if not zero
RegWrite  out  1  register file write
ALUControl  out  ALUCTRL_W  ALU operation
mem_req  out  1  memory access in progress
illegal_op  out  1  one-cycle pulse, unknown opcode
mem_err  out  1  one-cycle pulse, memory timeout
retired  out  CNT_W  completed-instruction count

Behaviour:
Reset and output timing
- On a clk edge with rst=1: state<=FETCH, wait counter<=0, retired<=0.
- While rst=1, every output is forced to 0. This includes ALUControl, which is forced to 0 rather than the add code.
- Outputs are decoded combinationally from state, except IRWrite/PCWrite in FETCH, which are qualified by mem_ready.
- Any signal not listed for a state is 0.

Memory handshake (FETCH, MEMRD, MEMWR)
- mem_req=1 in these states. Hold the state until mem_ready=1, then take the listed transition.
- Wait counter increments each cycle the state holds and clears on every state change.
- When the counter reaches TIMEOUT with mem_ready=0: pulse mem_err, go to FETCH, no retire.
- mem_ready=1 on the TIMEOUT cycle wins: normal transition, no mem_err.

State table
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=mem_ready. Go to DECODE on mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 or 000101 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other -> ILLEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if Opcode=100011, else MEMWR.
- MEMRD: IorD=1. Go to MEMWB on mem_ready.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH, retire.
- MEMWR: IorD=1, MemWrite=1 for the whole state; the write commits on the mem_ready cycle. Go to FETCH on mem_ready, retire.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Go to FETCH, retire.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01. Branch=1 if Opcode=000100; BranchNe=1 if Opcode=000101. Go to FETCH, retire.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH, retire.
- JUMP: PCSrc=10, PCWrite=1. Go to FETCH, retire.
- ILLEGAL: illegal_op=1. Go to FETCH, no retire.

Instruction latencies (memory at zero wait)
- 5 cycles: lw.
- 4 cycles: sw, R-type, addi.
- 3 cycles: beq, bne, j.

Retire counter
- "Retire" means retired increments by 1 on that transition edge; it wraps modulo 2^CNT_W.

ALU decode
- ALUOp 00 -> 010 (add); 01 -> 110 (sub); 11 -> 010.
- ALUOp 10 decodes Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other -> 010.

Reset mid-operation
- rst during any state, including a memory wait, aborts the instruction: no retire, no error pulses, FETCH on the next cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encoding (4-bit enum)
  - opcode constants
  - Funct constants
  - ALUOp codes
  - 3-bit ALUControl codes
- One combinational sub-module, mc_alu_dec, maps (ALUOp, Funct) to ALUControl and is parametrised by ALUCTRL_W.
- FSM, wait counter and retire counter stay in the top block.

Test Plan:
- Reset: rst=1 for 2 cycles mid-MEMRD wait -> all outputs 0 during rst; first cycle after release is FETCH with mem_req=1; retired=0.
- lw, mem_ready always 1: Opcode=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; RegWrite=1 and MemtoReg=1 in cycle 5; retired 0 -> 1.
- R-type slt then addi: Opcode=000000, Funct=101010 -> ALUControl=111 in EXEC, RegDst=1 in ALUWB. Then Opcode=001000 -> ALUControl=010 in ADDIEX, RegDst=0 in ADDIWB. retired = 2.
- bne/j: Opcode=000101 -> BranchNe=1, Branch=0, PCSrc=01 in the 3rd cycle. Opcode=000010 -> PCWrite=1, PCSrc=10 in the 3rd cycle.
- sw with 3 wait cycles: mem_ready low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, FETCH next, retired +1, mem_err=0.
- Timeout and illegal: TIMEOUT=15, mem_ready held 0 in FETCH -> mem_err pulse after 15 waits, FETCH re-entered, retired unchanged. Opcode=111111 -> illegal_op pulse in cycle 3, then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle MIPS control unit.
//   - state_t   : 4-bit FSM state encoding (S_FETCH is 0 so a zeroed debug
//                 bus during reset still reads as FETCH)
//   - OP_*      : instruction[31:26] opcodes recognised by the decoder
//   - FN_*      : instruction[5:0] funct codes for R-type ALU operations
//   - aluop_t   : main-decoder to ALU-decoder operation class
//   - ALU_*     : 3-bit ALUControl codes (zero-extended to ALUCTRL_W)
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_RSVD  = 2'b11
   } aluop_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: bundle between the control unit and the datapath.
//   Inputs to the controller : Opcode, Funct (from the instruction register),
//                              mem_ready (memory handshake)
//   Outputs of the controller: datapath mux selects, write enables,
//                              ALUControl, mem_req, illegal_op, mem_err,
//                              retired, dbg_state (current FSM state)
//   Modports: master = control unit, slave = datapath / memory side.
//
// Memory handshake: mem_req is the request (valid) and stays high for every
// cycle the FSM sits in FETCH, MEMRD or MEMWR. mem_ready is the completion
// (ready): an access completes on exactly the cycle where mem_req and
// mem_ready are both high, and the FSM leaves the memory state on that edge.
// mem_ready sampled while mem_req is low has no effect.
interface multicycle_ctrl_fsm_if #(
   parameter int ALUCTRL_W = 3,
   parameter int CNT_W     = 32
);
   import mc_ctrl_pkg::*;

   logic [5:0]           Opcode;
   logic [5:0]           Funct;
   logic                 mem_ready;

   logic                 MemtoReg;
   logic                 RegDst;
   logic                 IorD;
   logic [1:0]           PCSrc;
   logic [1:0]           ALUSrcB;
   logic                 ALUSrcA;
   logic                 IRWrite;
   logic                 MemWrite;
   logic                 PCWrite;
   logic                 Branch;
   logic                 BranchNe;
   logic                 RegWrite;
   logic [ALUCTRL_W-1:0] ALUControl;
   logic                 mem_req;
   logic                 illegal_op;
   logic                 mem_err;
   logic [CNT_W-1:0]     retired;
   state_t               dbg_state;

   modport master (
      input  Opcode, Funct, mem_ready,
      output MemtoReg, RegDst, IorD, PCSrc, ALUSrcB, ALUSrcA, IRWrite,
             MemWrite, PCWrite, Branch, BranchNe, RegWrite, ALUControl,
             mem_req, illegal_op, mem_err, retired, dbg_state
   );

   modport slave (
      output Opcode, Funct, mem_ready,
      input  MemtoReg, RegDst, IorD, PCSrc, ALUSrcB, ALUSrcA, IRWrite,
             MemWrite, PCWrite, Branch, BranchNe, RegWrite, ALUControl,
             mem_req, illegal_op, mem_err, retired, dbg_state
   );

endinterface

// File: rtl/multicycle_ctrl_fsm_alu_dec.sv
// mc_alu_dec: combinational ALU decoder.
//   aluop       in  operation class from the main decoder
//   funct       in  instruction[5:0], only consulted for ALUOP_FUNCT
//   alu_control out ALUCTRL_W-bit ALU code (3-bit code zero-extended)
module mc_alu_dec
   import mc_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W = 3
) (
   input  aluop_t               aluop,
   input  logic [5:0]           funct,
   output logic [ALUCTRL_W-1:0] alu_control
);

   logic [2:0] code;

   always_comb begin
      code = ALU_ADD;
      case (aluop)
         ALUOP_SUB: code = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  code = ALU_ADD;
               FN_SUB:  code = ALU_SUB;
               FN_AND:  code = ALU_AND;
               FN_OR:   code = ALU_OR;
               FN_SLT:  code = ALU_SLT;
               default: code = ALU_ADD;
            endcase
         end
         // ALUOP_ADD and the reserved ALUOP_RSVD both mean add
         default: code = ALU_ADD;
      endcase
   end

   assign alu_control = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multicycle MIPS control unit (lw, sw, R-type, beq,
// bne, addi, j) with a memory wait/timeout handshake, illegal-opcode trap
// and a retired-instruction counter.
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset; forces every output to 0
//   bus  master side of multicycle_ctrl_fsm_if (Opcode/Funct/mem_ready in,
//        datapath controls, status pulses, retired count, dbg_state out)
module multicycle_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W   = 3,
   parameter int MEM_WAIT_EN = 1,
   parameter int TIMEOUT     = 15,
   parameter int CNT_W       = 32
) (
   input logic                  clk,
   input logic                  rst,
   multicycle_ctrl_fsm_if.master bus
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_t               state, next_state;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [CNT_W-1:0]     retired_q;
   logic                 ready, timeout, hold, retire;

   logic                 memtoreg, regdst, iord, alusrca, irwrite, memwrite;
   logic                 pcwrite, branch, branchne, regwrite;
   logic                 mem_req, illegal_op, mem_err;
   logic [1:0]           pcsrc, alusrcb;
   aluop_t               aluop;
   logic [ALUCTRL_W-1:0] alu_control;

   assign ready   = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;
   assign timeout = (wait_cnt == WAIT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         wait_cnt  <= '0;
         retired_q <= '0;
      end else begin
         state    <= next_state;
         // hold is only set while a memory state is waiting, so any state
         // change (including a timeout back into FETCH) clears the counter
         wait_cnt <= hold ? wait_cnt + WAIT_W'(1) : '0;
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      next_state = state;
      hold       = 1'b0;
      retire     = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      iord       = 1'b0;
      pcsrc      = 2'b00;
      alusrcb    = 2'b00;
      alusrca    = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branchne   = 1'b0;
      regwrite   = 1'b0;
      mem_req    = 1'b0;
      illegal_op = 1'b0;
      mem_err    = 1'b0;
      aluop      = ALUOP_ADD;

      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            irwrite = ready;
            pcwrite = ready;
            if (ready) begin
               next_state = S_DECODE;
            end else if (timeout) begin
               mem_err    = 1'b1;
               next_state = S_FETCH;
            end else begin
               hold = 1'b1;
            end
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (bus.Opcode)
               OP_LW, OP_SW:   next_state = S_MEMADR;
               OP_RTYPE:       next_state = S_EXEC;
               OP_BEQ, OP_BNE: next_state = S_BRANCH;
               OP_ADDI:        next_state = S_ADDIEX;
               OP_J:           next_state = S_JUMP;
               default:        next_state = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            next_state = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (ready) begin
               next_state = S_MEMWB;
            end else if (timeout) begin
               mem_err    = 1'b1;
               next_state = S_FETCH;
            end else begin
               hold = 1'b1;
            end
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
            if (ready) begin
               retire     = 1'b1;
               next_state = S_FETCH;
            end else if (timeout) begin
               mem_err    = 1'b1;
               next_state = S_FETCH;
            end else begin
               hold = 1'b1;
            end
         end
         S_EXEC: begin
            alusrca    = 1'b1;
            aluop      = ALUOP_FUNCT;
            next_state = S_ALUWB;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            aluop      = ALUOP_SUB;
            pcsrc      = 2'b01;
            branch     = (bus.Opcode == OP_BEQ);
            branchne   = (bus.Opcode == OP_BNE);
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            next_state = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite   = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_JUMP: begin
            pcsrc      = 2'b10;
            pcwrite    = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_ILLEGAL: begin
            illegal_op = 1'b1;
            next_state = S_FETCH;
         end
         default: next_state = S_FETCH;
      endcase
   end

   mc_alu_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
      .aluop       (aluop),
      .funct       (bus.Funct),
      .alu_control (alu_control)
   );

   // While rst is high every output reads 0, including ALUControl (which
   // would otherwise show the add code) and the retired count.
   assign bus.MemtoReg   = memtoreg   & ~rst;
   assign bus.RegDst     = regdst     & ~rst;
   assign bus.IorD       = iord       & ~rst;
   assign bus.PCSrc      = rst ? 2'b00 : pcsrc;
   assign bus.ALUSrcB    = rst ? 2'b00 : alusrcb;
   assign bus.ALUSrcA    = alusrca    & ~rst;
   assign bus.IRWrite    = irwrite    & ~rst;
   assign bus.MemWrite   = memwrite   & ~rst;
   assign bus.PCWrite    = pcwrite    & ~rst;
   assign bus.Branch     = branch     & ~rst;
   assign bus.BranchNe   = branchne   & ~rst;
   assign bus.RegWrite   = regwrite   & ~rst;
   assign bus.ALUControl = rst ? '0 : alu_control;
   assign bus.mem_req    = mem_req    & ~rst;
   assign bus.illegal_op = illegal_op & ~rst;
   assign bus.mem_err    = mem_err    & ~rst;
   assign bus.retired    = rst ? '0 : retired_q;
   assign bus.dbg_state  = rst ? S_FETCH : state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: every cycle the expected output
// vector is pushed when the inputs are driven and popped when sampled.
module tb_multicycle_ctrl_fsm;
   import mc_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multicycle_ctrl_fsm_if #(.ALUCTRL_W(3), .CNT_W(32)) bus ();

   multicycle_ctrl_fsm #(
      .ALUCTRL_W   (3),
      .MEM_WAIT_EN (1),
      .TIMEOUT     (15),
      .CNT_W       (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [23:0] exp_q[$];
   logic [23:0] msk_q[$];
   logic [31:0] exp_ret;
   logic [5:0]  opc, fn;
   logic [5:0]  r_fns [0:5];
   logic [2:0]  r_alu [0:5];
   int          n_vec = 0;
   int          n_err = 0;

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [2:0] ref_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Vector layout: state[23:20] MemtoReg RegDst IorD PCSrc[2] ALUSrcB[2]
   // ALUSrcA IRWrite MemWrite PCWrite Branch BranchNe RegWrite ALU[5:3]
   // mem_req illegal_op mem_err
   function automatic logic [23:0] model(input state_t st, input logic [5:0] op,
                                         input logic [5:0] f, input logic r,
                                         input logic e);
      logic m2r, rdst, iord, srca, irw, mw, pcw, br, brn, rw, req, ill;
      logic [1:0] pcs, srcb;
      logic [2:0] alu;
      m2r = 0; rdst = 0; iord = 0; srca = 0; irw = 0; mw = 0; pcw = 0;
      br = 0; brn = 0; rw = 0; req = 0; ill = 0; pcs = 2'b00; srcb = 2'b00;
      alu = 3'b010;
      case (st)
         S_FETCH:   begin req = 1; srcb = 2'b01; irw = r; pcw = r; end
         S_DECODE:  srcb = 2'b11;
         S_MEMADR:  begin srca = 1; srcb = 2'b10; end
         S_MEMRD:   begin req = 1; iord = 1; end
         S_MEMWB:   begin m2r = 1; rw = 1; end
         S_MEMWR:   begin req = 1; iord = 1; mw = 1; end
         S_EXEC:    begin srca = 1; alu = ref_alu(f); end
         S_ALUWB:   begin rdst = 1; rw = 1; end
         S_BRANCH:  begin
            srca = 1; alu = 3'b110; pcs = 2'b01;
            br = (op == 6'b000100); brn = (op == 6'b000101);
         end
         S_ADDIEX:  begin srca = 1; srcb = 2'b10; end
         S_ADDIWB:  rw = 1;
         S_JUMP:    begin pcs = 2'b10; pcw = 1; end
         S_ILLEGAL: ill = 1;
         default:   ;
      endcase
      return {st, m2r, rdst, iord, pcs, srcb, srca, irw, mw, pcw, br, brn, rw,
              alu, req, ill, e};
   endfunction

   // ALUControl is only compared in states that name an ALU operation
   function automatic logic [23:0] mask_for(input state_t st);
      if (st inside {S_FETCH, S_DECODE, S_MEMADR, S_EXEC, S_BRANCH, S_ADDIEX})
         return 24'hFFFFFF;
      return 24'hFFFFC7;
   endfunction

   function automatic logic [23:0] observe();
      return {bus.dbg_state, bus.MemtoReg, bus.RegDst, bus.IorD, bus.PCSrc,
              bus.ALUSrcB, bus.ALUSrcA, bus.IRWrite, bus.MemWrite, bus.PCWrite,
              bus.Branch, bus.BranchNe, bus.RegWrite, bus.ALUControl,
              bus.mem_req, bus.illegal_op, bus.mem_err};
   endfunction

   task automatic check_vec(input string tag);
      logic [23:0] e, m, o;
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      o = observe();
      n_vec++;
      assert ((o & m) === (e & m)) else begin
         n_err++;
         $error("FAIL %s: outputs got %h exp %h", tag, o & m, e & m);
      end
      n_vec++;
      assert (bus.retired === exp_ret) else begin
         n_err++;
         $error("FAIL %s.retired: got %0d exp %0d", tag, bus.retired, exp_ret);
      end
   endtask

   task automatic step(input state_t st, input logic rdy, input logic err,
                       input logic ret, input string tag);
      @(negedge clk);
      rst           = 1'b0;
      bus.Opcode    = opc;
      bus.Funct     = fn;
      bus.mem_ready = rdy;
      exp_q.push_back(model(st, opc, fn, rdy, err));
      msk_q.push_back(mask_for(st));
      #1;
      check_vec(tag);
      if (ret) exp_ret = exp_ret + 32'd1;
   endtask

   task automatic reset_step(input string tag);
      @(negedge clk);
      rst           = 1'b1;
      bus.mem_ready = rnd_bit();
      exp_ret       = 32'd0;
      exp_q.push_back(24'h000000);
      msk_q.push_back(24'hFFFFFF);
      #1;
      check_vec(tag);
   endtask

   initial begin
      bus.Opcode = 6'd0; bus.Funct = 6'd0; bus.mem_ready = 1'b0;
      opc = 6'd0; fn = 6'd0; exp_ret = 32'd0;
      r_fns[0] = 6'b101010; r_alu[0] = 3'b111;
      r_fns[1] = 6'b100000; r_alu[1] = 3'b010;
      r_fns[2] = 6'b100010; r_alu[2] = 3'b110;
      r_fns[3] = 6'b100100; r_alu[3] = 3'b000;
      r_fns[4] = 6'b100101; r_alu[4] = 3'b001;
      r_fns[5] = 6'b000000; r_alu[5] = 3'b010;

      reset_step("rst0");
      reset_step("rst1");

      // lw, memory always ready
      opc = 6'b100011; fn = 6'($urandom_range(0, 63));
      step(S_FETCH,  1'b1, 1'b0, 1'b0, "lw.fetch");
      step(S_DECODE, rnd_bit(), 1'b0, 1'b0, "lw.decode");
      step(S_MEMADR, rnd_bit(), 1'b0, 1'b0, "lw.memadr");
      step(S_MEMRD,  1'b1, 1'b0, 1'b0, "lw.memrd");
      step(S_MEMWB,  rnd_bit(), 1'b0, 1'b1, "lw.memwb");

      // R-type: slt first, then the remaining funct codes
      opc = 6'b000000;
      for (int i = 0; i < 6; i++) begin
         fn = r_fns[i];
         step(S_FETCH,  1'b1, 1'b0, 1'b0, $sformatf("r%0d.fetch", i));
         step(S_DECODE, rnd_bit(), 1'b0, 1'b0, $sformatf("r%0d.decode", i));
         step(S_EXEC,   rnd_bit(), 1'b0, 1'b0, $sformatf("r%0d.exec", i));
         n_vec++;
         assert (bus.ALUControl === r_alu[i]) else begin
            n_err++;
            $error("FAIL r%0d.aluctl: got %b exp %b", i, bus.ALUControl, r_alu[i]);
         end
         step(S_ALUWB,  rnd_bit(), 1'b0, 1'b1, $sformatf("r%0d.aluwb", i));
      end

      // addi
      opc = 6'b001000; fn = 6'($urandom_range(0, 63));
      step(S_FETCH,  1'b1, 1'b0, 1'b0, "addi.fetch");
      step(S_DECODE, rnd_bit(), 1'b0, 1'b0, "addi.decode");
      step(S_ADDIEX, rnd_bit(), 1'b0, 1'b0, "addi.ex");
      step(S_ADDIWB, rnd_bit(), 1'b0, 1'b1, "addi.wb");

      // beq, bne, j
      opc = 6'b000100;
      step(S_FETCH,  1'b1, 1'b0, 1'b0, "beq.fetch");
      step(S_DECODE, rnd_bit(), 1'b0, 1'b0, "beq.decode");
      step(S_BRANCH, rnd_bit(), 1'b0, 1'b1, "beq.branch");
      opc = 6'b000101;
      step(S_FETCH,  1'b1, 1'b0, 1'b0, "bne.fetch");
      step(S_DECODE, rnd_bit(), 1'b0, 1'b0, "bne.decode");
      step(S_BRANCH, rnd_bit(), 1'b0, 1'b1, "bne.branch");
      opc = 6'b000010;
      step(S_FETCH,  1'b1, 1'b0, 1'b0, "j.fetch");
      step(S_DECODE, rnd_bit(), 1'b0, 1'b0, "j.decode");
      step(S_JUMP,   rnd_bit(), 1'b0, 1'b1, "j.jump");

      // sw with three wait cycles
      opc = 6'b101011;
      step(S_FETCH,  1'b1, 1'b0, 1'b0, "sw.fetch");
      step(S_DECODE, rnd_bit(), 1'b0, 1'b0, "sw.decode");
      step(S_MEMADR, rnd_bit(), 1'b0, 1'b0, "sw.memadr");
      for (int i = 0; i < 3; i++)
         step(S_MEMWR, 1'b0, 1'b0, 1'b0, $sformatf("sw.wait%0d", i));
      step(S_MEMWR,  1'b1, 1'b0, 1'b1, "sw.commit");

      // fetch timeout: 15 waits, then the error pulse, then a clean FETCH
      for (int i = 0; i < 15; i++)
         step(S_FETCH, 1'b0, 1'b0, 1'b0, $sformatf("fetch.wait%0d", i));
      step(S_FETCH, 1'b0, 1'b1, 1'b0, "fetch.timeout");
      step(S_FETCH, 1'b0, 1'b0, 1'b0, "fetch.after_to");

      // illegal opcode
      opc = 6'b111111;
      step(S_FETCH,   1'b1, 1'b0, 1'b0, "ill.fetch");
      step(S_DECODE,  rnd_bit(), 1'b0, 1'b0, "ill.decode");
      step(S_ILLEGAL, rnd_bit(), 1'b0, 1'b0, "ill.trap");

      // lw: ready arrives on the timeout cycle and wins
      opc = 6'b100011;
      step(S_FETCH,  1'b1, 1'b0, 1'b0, "lwto.fetch");
      step(S_DECODE, rnd_bit(), 1'b0, 1'b0, "lwto.decode");
      step(S_MEMADR, rnd_bit(), 1'b0, 1'b0, "lwto.memadr");
      for (int i = 0; i < 15; i++)
         step(S_MEMRD, 1'b0, 1'b0, 1'b0, $sformatf("lwto.wait%0d", i));
      step(S_MEMRD,  1'b1, 1'b0, 1'b0, "lwto.ready_at_limit");
      step(S_MEMWB,  rnd_bit(), 1'b0, 1'b1, "lwto.memwb");

      // sw: memory never answers, write aborted without retire
      opc = 6'b101011;
      step(S_FETCH,  1'b1, 1'b0, 1'b0, "swto.fetch");
      step(S_DECODE, rnd_bit(), 1'b0, 1'b0, "swto.decode");
      step(S_MEMADR, rnd_bit(), 1'b0, 1'b0, "swto.memadr");
      for (int i = 0; i < 15; i++)
         step(S_MEMWR, 1'b0, 1'b0, 1'b0, $sformatf("swto.wait%0d", i));
      step(S_MEMWR,  1'b0, 1'b1, 1'b0, "swto.timeout");
      step(S_FETCH,  1'b0, 1'b0, 1'b0, "swto.refetch");

      // reset in the middle of a MEMRD wait
      opc = 6'b100011;
      step(S_FETCH,  1'b1, 1'b0, 1'b0, "rlw.fetch");
      step(S_DECODE, rnd_bit(), 1'b0, 1'b0, "rlw.decode");
      step(S_MEMADR, rnd_bit(), 1'b0, 1'b0, "rlw.memadr");
      step(S_MEMRD,  1'b0, 1'b0, 1'b0, "rlw.wait0");
      step(S_MEMRD,  1'b0, 1'b0, 1'b0, "rlw.wait1");
      reset_step("rlw.rst0");
      reset_step("rlw.rst1");
      step(S_FETCH,  1'b1, 1'b0, 1'b0, "post_rst.fetch");
      step(S_DECODE, rnd_bit(), 1'b0, 1'b0, "post_rst.decode");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
